// File: rtl/param_dual_ram_pkg.sv
// Shared constants and types for the parameterised byte-lane dual-port RAM.
package param_dual_ram_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 6;
  localparam int unsigned DEF_LANE_W = 8;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Number of byte-enable lanes in a word.
  function automatic int unsigned lane_count(input int unsigned data_w, input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Power-on clear sequencer: sweeps every address once with a zero write,
// then parks in READY until the next reset.
module ram_init_seq
  import param_dual_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we_c
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_busy <= busy_d;
    end
  end

  // The sweep leaves INIT on the edge that writes the last address.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_c = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we_c = 1'b1;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_READY;
      end
      ST_READY: ;
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d == ST_INIT);
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/param_dual_ram.sv
// Byte-lane dual-port RAM with self-clearing init sweep and write-first reads.
// Define PARAM_DUAL_RAM_OUT_REG_EN to add a second output register stage (latency 2).
module param_dual_ram
  import param_dual_ram_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned LANE_W = DEF_LANE_W,
  localparam int unsigned NLANES = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [NLANES-1:0] w_be,
  input  logic [DATA_W-1:0] data_in,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              r_valid,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we_c;
  logic              ready_c;
  logic              wr_fire_c;
  logic              rd_fire_c;
  logic [DATA_W-1:0] rd_word_c;
  logic [DATA_W-1:0] s1_data_q;
  logic              s1_valid_q;

  ram_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_we_c  (clr_we_c)
  );

  assign ready_c   = ~init_busy;
  assign wr_fire_c = w_en & ready_c;
  assign rd_fire_c = r_en & ready_c;

  // Clear sweep has priority; user writes only land once READY.
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire_c) begin
      for (int unsigned l = 0; l < NLANES; l++) begin
        if (w_be[l]) mem[w_addr][l*LANE_W +: LANE_W] <= data_in[l*LANE_W +: LANE_W];
      end
    end
  end

  // Write-first bypass for lanes written to the address being read.
  always_comb begin
    rd_word_c = mem[r_addr];
    for (int unsigned l = 0; l < NLANES; l++) begin
      if (wr_fire_c && (w_addr == r_addr) && w_be[l]) begin
        rd_word_c[l*LANE_W +: LANE_W] = data_in[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= rd_fire_c;
      if (rd_fire_c) s1_data_q <= rd_word_c;
    end
  end

`ifdef PARAM_DUAL_RAM_OUT_REG_EN
  // Extra pipeline stage; data still reflects the request-time collision merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= s1_valid_q;
      if (s1_valid_q) data_out <= s1_data_q;
    end
  end
`else
  assign data_out = s1_data_q;
  assign r_valid  = s1_valid_q;
`endif

endmodule

// File: tb/tb_param_dual_ram.sv
// Scoreboard bench for param_dual_ram (DATA_W=32, ADDR_W=6, LANE_W=8).
module tb_param_dual_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned LW    = 8;
  localparam int unsigned NL    = 4;
  localparam int          DEPTH = 64;
`ifdef PARAM_DUAL_RAM_OUT_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          w_en = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [NL-1:0] w_be = '0;
  logic [DW-1:0] data_in = '0;
  logic          r_en = 1'b0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] data_out;
  logic          r_valid;
  logic          init_busy;

  param_dual_ram #(.DATA_W(DW), .ADDR_W(AW), .LANE_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_be      (w_be),
    .data_in   (data_in),
    .r_en      (r_en),
    .r_addr    (r_addr),
    .data_out  (data_out),
    .r_valid   (r_valid),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] mdl [DEPTH];
  int            init_cnt = 0;
  logic          ready_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                               input logic [NL-1:0] be, input logic hit);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < NL; l++) if (hit && be[l]) r[l*LW +: LW] = din[l*LW +: LW];
    return r;
  endfunction

  // Reference model: clear sweep, then lane writes and write-first reads.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= 0;
      ready_m  <= 1'b0;
      exp_q.delete();
    end else if (!ready_m) begin
      mdl[init_cnt] <= '0;
      if (init_cnt == DEPTH - 1) ready_m <= 1'b1;
      init_cnt <= init_cnt + 1;
    end else begin
      if (r_en) exp_q.push_back('{due: cyc + L,
                                  data: merge_word(mdl[r_addr], data_in, w_be, w_en && (w_addr == r_addr))});
      if (w_en)
        for (int l = 0; l < NL; l++)
          if (w_be[l]) mdl[w_addr][l*LW +: LW] <= data_in[l*LW +: LW];
    end
  end

  // Output monitor: every r_valid must match the oldest expected read, on its due cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_r_valid: no result by cycle %0d, required data %h due cycle %0d",
                 cyc, exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (r_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_r_valid: got data %h at cycle %0d, required no r_valid", data_out, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (data_out !== e.data || e.due != cyc) begin
            failures++;
            $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                     data_out, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [NL-1:0] be,
                       input logic [DW-1:0] d, input logic re, input logic [AW-1:0] ra);
    @(posedge clk);
    #1;
    w_en = we; w_addr = wa; w_be = be; data_in = d; r_en = re; r_addr = ra;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (init_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || r_valid !== 1'b0 || init_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: data_out=%h r_valid=%b init_busy=%b, required 0/0/1",
               data_out, r_valid, init_busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL init_busy_len: %0d cycles, required %0d", n, DEPTH);
    end
  endtask

  task automatic test_init_zero;
    drive(1'b0, '0, '0, '0, 1'b1, 6'd0);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd31);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd63);
    idle(1);
    drain("init_zero");
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL init_zero: data_out=%h, required 00000000", data_out);
    end
  endtask

  task automatic test_lane_merge;
    drive(1'b1, 6'd5, 4'b1111, 32'hDEADBEEF, 1'b0, '0);
    drive(1'b1, 6'd5, 4'b0010, 32'h0000AA00, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd5);
    idle(1);
    drain("lane_merge");
    checks++;
    if (data_out !== 32'hDEADAAEF) begin
      failures++;
      $display("FAIL lane_merge: data_out=%h, required deadaaef", data_out);
    end
    drive(1'b1, 6'd5, 4'b0000, 32'hFFFFFFFF, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd5);
    idle(1);
    drain("be_zero");
    checks++;
    if (data_out !== 32'hDEADAAEF) begin
      failures++;
      $display("FAIL be_zero_noop: data_out=%h, required deadaaef", data_out);
    end
  endtask

  task automatic test_collision;
    drive(1'b1, 6'd10, 4'b1111, 32'h00000010, 1'b0, '0);
    drive(1'b1, 6'd9, 4'b1111, 32'h0000005A, 1'b1, 6'd9);
    idle(1);
    drain("collide_same");
    checks++;
    if (data_out !== 32'h0000005A) begin
      failures++;
      $display("FAIL collide_same: data_out=%h, required 0000005a", data_out);
    end
    drive(1'b1, 6'd9, 4'b1111, 32'h00000066, 1'b1, 6'd10);
    idle(1);
    drain("collide_other");
    checks++;
    if (data_out !== 32'h00000010) begin
      failures++;
      $display("FAIL collide_other: data_out=%h, required 00000010", data_out);
    end
    drive(1'b1, 6'd10, 4'b0001, 32'hFFFFFFAB, 1'b1, 6'd10);
    idle(1);
    drain("collide_partial");
    checks++;
    if (data_out !== 32'h000000AB) begin
      failures++;
      $display("FAIL collide_partial: data_out=%h, required 000000ab", data_out);
    end
  endtask

  task automatic test_back_to_back;
    int vcnt;
    for (int i = 1; i <= 4; i++) drive(1'b1, AW'(i), 4'b1111, DW'(i * 32'h11), 1'b0, '0);
    for (int i = 1; i <= 4; i++) drive(1'b1, 6'd20, 4'b1111, DW'(i), 1'b1, AW'(i));
    vcnt = 0;
    for (int i = 0; i < L + 2; i++) begin
      drive(1'b0, '0, '0, '0, 1'b0, '0);
      if (r_valid === 1'b1) vcnt++;
    end
    drain("back_to_back");
    checks++;
    if (data_out !== 32'h00000044) begin
      failures++;
      $display("FAIL back_to_back_last: data_out=%h, required 00000044", data_out);
    end
  endtask

  task automatic test_init_ignore;
    int n;
    int vcnt;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 55; i++) begin
      drive(1'b1, 6'd0, 4'b1111, 32'hA5A5A5A5, 1'b1, 6'd0);
      if (r_valid !== 1'b0) vcnt++;
    end
    idle(1);
    wait_ready(n);
    checks++;
    if (vcnt != 0) begin
      failures++;
      $display("FAIL init_ignore_valid: %0d r_valid pulses during INIT, required 0", vcnt);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 6'd0);
    idle(1);
    drain("init_ignore");
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL init_ignore_mem: data_out=%h, required 00000000", data_out);
    end
  endtask

  task automatic test_reset_mid_read;
    int n;
    int vcnt;
    drive(1'b1, 6'd7, 4'b1111, 32'h12345678, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd7);
    #2 rst_n = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, '0, 1'b0, '0);
      if (r_valid !== 1'b0) vcnt++;
    end
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (vcnt != 0) begin
      failures++;
      $display("FAIL mid_read_abort: %0d r_valid pulses, required 0", vcnt);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    drive(1'b1, 6'd3, 4'b1111, 32'h00000077, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 6'd3);
    idle(1);
    drain("pre_sweep");
    checks++;
    if (data_out !== 32'h00000077) begin
      failures++;
      $display("FAIL pre_sweep_read: data_out=%h, required 00000077", data_out);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(20);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || r_valid !== 1'b0 || init_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_reset: data_out=%h r_valid=%b init_busy=%b, required 0/0/1",
               data_out, r_valid, init_busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      failures++;
      $display("FAIL sweep_restart_len: %0d cycles, required %0d", n, DEPTH);
    end
    drive(1'b0, '0, '0, '0, 1'b1, 6'd3);
    idle(1);
    drain("post_sweep");
    checks++;
    if (data_out !== 32'h0) begin
      failures++;
      $display("FAIL post_sweep_read: data_out=%h, required 00000000", data_out);
    end
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_lane_merge();
    test_collision();
    test_back_to_back();
    test_init_ignore();
    test_reset_mid_read();
    test_reset_mid_sweep();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
